// File: rtl/pipelined_control_unit.sv
// Registered RV32I(M) control decoder between fetch and execute, with
// valid/ready handshake, load-use bubble insertion, flush and an illegal counter.
package alu_op_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;
endpackage

module pipelined_control_unit
    import alu_op_pkg::*;
#(
    parameter bit          ENABLE_M      = 1'b1,
    parameter bit          ENABLE_JUMP   = 1'b1,
    parameter int unsigned ILLEGAL_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     Branch,
    output logic                     MemRead,
    output logic                     MemtoReg,
    output logic                     MemWrite,
    output logic                     ALUSrc,
    output logic                     RegWrite,
    output alu_op_t                  ALUOp,
    output logic [1:0]               MemReadSize,
    output logic                     MemReadSigned,
    output logic                     Jump,
    output logic                     JumpReg,
    output logic                     MulDiv,
    output logic [2:0]               funct3_o,
    output logic [4:0]               rd,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic                     Illegal,
    output logic [ILLEGAL_CNT_W-1:0] illegal_count
);
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        alu_op_t    alu_op;
        logic [1:0] size;
        logic       sgn;
        logic       jump;
        logic       jump_reg;
        logic       mul_div;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    function automatic alu_op_t alu_map(input logic [2:0] fn, input logic alt);
        alu_op_t op;
        case (fn)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    bundle_t dec;
    logic    legal;

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            OpLoad: begin
                legal          = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.size       = f3[1:0];
                dec.sgn        = !f3[2];
            end
            OpStore: begin
                legal         = f3 inside {3'b000, 3'b001, 3'b010};
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OpBranch: begin
                legal      = !(f3 inside {3'b010, 3'b011});
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OpImm: begin
                // Only shifts carry a funct7; ADDI never becomes SUB.
                if (f3 == 3'b001)      legal = (f7 == 7'h00);
                else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                   legal = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_map(f3, (f3 == 3'b101) && f7[5]);
            end
            OpReg: begin
                dec.reg_write = 1'b1;
                if (ENABLE_M && f7 == 7'h01) begin
                    legal       = 1'b1;
                    dec.mul_div = 1'b1;
                end else if (f7 == 7'h00) begin
                    legal      = 1'b1;
                    dec.alu_op = alu_map(f3, 1'b0);
                end else if (f7 == 7'h20) begin
                    legal      = (f3 == 3'b000) || (f3 == 3'b101);
                    dec.alu_op = alu_map(f3, 1'b1);
                end
            end
            OpJal: begin
                legal         = ENABLE_JUMP;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpJalr: begin
                legal         = ENABLE_JUMP && (f3 == 3'b000);
                dec.jump      = 1'b1;
                dec.jump_reg  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpLui, OpAuipc: begin
                legal         = ENABLE_JUMP;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.funct3 = f3;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
    end

    logic                     out_valid_q, out_valid_d;
    bundle_t                  bundle_q, bundle_d;
    logic [ILLEGAL_CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic                     uses_rs1, uses_rs2, stall, accept;

    assign uses_rs1 = !(opcode inside {OpLui, OpAuipc, OpJal});
    assign uses_rs2 = opcode inside {OpReg, OpStore, OpBranch};

    // Stalling only while the load is leaving guarantees exactly one bubble.
    assign stall = out_valid_q && bundle_q.mem_read && (bundle_q.rd != 5'd0) && in_valid &&
                   out_ready && ((uses_rs1 && instr[19:15] == bundle_q.rd) ||
                                 (uses_rs2 && instr[24:20] == bundle_q.rd));
    assign in_ready = !rst && !flush && !stall && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        bundle_d      = bundle_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            bundle_d    = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
            if (dec.illegal && illegal_cnt_q != {ILLEGAL_CNT_W{1'b1}}) begin
                illegal_cnt_d = illegal_cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            bundle_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            bundle_q      <= '0;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            bundle_q      <= bundle_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign Branch        = bundle_q.branch;
    assign MemRead       = bundle_q.mem_read;
    assign MemtoReg      = bundle_q.mem_to_reg;
    assign MemWrite      = bundle_q.mem_write;
    assign ALUSrc        = bundle_q.alu_src;
    assign RegWrite      = bundle_q.reg_write;
    assign ALUOp         = bundle_q.alu_op;
    assign MemReadSize   = bundle_q.size;
    assign MemReadSigned = bundle_q.sgn;
    assign Jump          = bundle_q.jump;
    assign JumpReg       = bundle_q.jump_reg;
    assign MulDiv        = bundle_q.mul_div;
    assign funct3_o      = bundle_q.funct3;
    assign rd            = bundle_q.rd;
    assign rs1           = bundle_q.rs1;
    assign rs2           = bundle_q.rs2;
    assign Illegal       = bundle_q.illegal;
    assign illegal_count = illegal_cnt_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: one full-featured and one M/jump-disabled decoder share stimulus;
// a reference model predicts handshakes and bundles, a monitor pops and compares.
module tb_pipelined_control_unit;
    import alu_op_pkg::*;

    typedef struct packed {
        logic       branch, memread, memtoreg, memwrite, alusrc, regwrite;
        alu_op_t    aluop;
        logic [1:0] size;
        logic       sgn, jump, jumpreg, muldiv;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic       illegal;
    } bundle_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = 32'h0;

    logic       ir_a, ov_a, br_a, mr_a, m2r_a, mw_a, as_a, rw_a, sg_a, j_a, jr_a, md_a, il_a;
    alu_op_t    op_a;
    logic [1:0] sz_a;
    logic [2:0] f3_a;
    logic [4:0] rd_a, rs1_a, rs2_a;
    logic [7:0] cnt_a;
    logic       ir_b, ov_b, br_b, mr_b, m2r_b, mw_b, as_b, rw_b, sg_b, j_b, jr_b, md_b, il_b;
    alu_op_t    op_b;
    logic [1:0] sz_b;
    logic [2:0] f3_b;
    logic [4:0] rd_b, rs1_b, rs2_b;
    logic [7:0] cnt_b;

    pipelined_control_unit #(.ENABLE_M(1'b1), .ENABLE_JUMP(1'b1), .ILLEGAL_CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .instr(instr),
        .flush(flush), .out_valid(ov_a), .out_ready(out_ready), .Branch(br_a),
        .MemRead(mr_a), .MemtoReg(m2r_a), .MemWrite(mw_a), .ALUSrc(as_a), .RegWrite(rw_a),
        .ALUOp(op_a), .MemReadSize(sz_a), .MemReadSigned(sg_a), .Jump(j_a), .JumpReg(jr_a),
        .MulDiv(md_a), .funct3_o(f3_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a),
        .Illegal(il_a), .illegal_count(cnt_a)
    );
    pipelined_control_unit #(.ENABLE_M(1'b0), .ENABLE_JUMP(1'b0), .ILLEGAL_CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .instr(instr),
        .flush(flush), .out_valid(ov_b), .out_ready(out_ready), .Branch(br_b),
        .MemRead(mr_b), .MemtoReg(m2r_b), .MemWrite(mw_b), .ALUSrc(as_b), .RegWrite(rw_b),
        .ALUOp(op_b), .MemReadSize(sz_b), .MemReadSigned(sg_b), .Jump(j_b), .JumpReg(jr_b),
        .MulDiv(md_b), .funct3_o(f3_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b),
        .Illegal(il_b), .illegal_count(cnt_b)
    );

    int      checks = 0, errors = 0;
    bundle_t q_a[$], q_b[$];
    int      exp_cnt_a = 0, exp_cnt_b = 0;
    bit      m_valid = 0;
    logic [4:0] m_load_rd = 5'd0;
    bit      mon_en = 0;

    // Reference decode straight from the instruction-set rules.
    function automatic bundle_t ref_decode(input logic [31:0] i, input bit en_m, input bit en_j);
        bundle_t    b;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit         ok;
        alu_op_t    tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        b  = '0;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        ok = 0;
        if (op == 7'h03) begin
            ok = (f3 != 3) && (f3 != 6) && (f3 != 7);
            b.memread = 1; b.memtoreg = 1; b.alusrc = 1; b.regwrite = 1;
            b.size = f3[1:0]; b.sgn = (f3 < 4);
        end else if (op == 7'h23) begin
            ok = (f3 <= 2);
            b.memwrite = 1; b.alusrc = 1;
        end else if (op == 7'h63) begin
            ok = (f3 != 2) && (f3 != 3);
            b.branch = 1; b.aluop = ALU_SUB;
        end else if (op == 7'h13) begin
            ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
            b.alusrc = 1; b.regwrite = 1;
            b.aluop = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : tbl[f3];
        end else if (op == 7'h33) begin
            b.regwrite = 1;
            if (f7 == 7'h01 && en_m) begin
                ok = 1; b.muldiv = 1;
            end else if (f7 == 0) begin
                ok = 1; b.aluop = tbl[f3];
            end else if (f7 == 7'h20 && f3 == 0) begin
                ok = 1; b.aluop = ALU_SUB;
            end else if (f7 == 7'h20 && f3 == 5) begin
                ok = 1; b.aluop = ALU_SRA;
            end
        end else if (op == 7'h6F) begin
            ok = en_j; b.jump = 1; b.regwrite = 1;
        end else if (op == 7'h67) begin
            ok = en_j && (f3 == 0); b.jump = 1; b.jumpreg = 1; b.alusrc = 1; b.regwrite = 1;
        end else if (op == 7'h37 || op == 7'h17) begin
            ok = en_j; b.alusrc = 1; b.regwrite = 1;
        end
        if (!ok) begin
            b = '0;
            b.illegal = 1;
        end
        b.f3 = f3; b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20];
        return b;
    endfunction

    function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
        logic [6:0] op;
        op = i[6:0];
        if (op != 7'h37 && op != 7'h17 && op != 7'h6F && i[19:15] == r) return 1;
        if ((op == 7'h33 || op == 7'h23 || op == 7'h63) && i[24:20] == r) return 1;
        return 0;
    endfunction

    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic fl, input logic rs, output bit acc);
        bit      hz, er;
        bundle_t ea, eb;
        @(posedge clk);
        #1;
        in_valid = iv; instr = ins; out_ready = ordy; flush = fl; rst = rs;
        @(negedge clk);
        #1;
        hz = m_valid && m_load_rd != 0 && iv && ordy && reads_reg(ins, m_load_rd);
        er = !rs && !fl && !hz && (!m_valid || ordy);
        checks++;
        if (ir_a !== er || ir_b !== er)
            $display("FAIL in_ready instr=%h got a=%b b=%b exp=%b", ins, ir_a, ir_b, er);
        if (ir_a !== er || ir_b !== er) errors++;
        acc = iv && er;
        if (rs) begin
            m_valid = 0; m_load_rd = 0; exp_cnt_a = 0; exp_cnt_b = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (acc) begin
            ea = ref_decode(ins, 1, 1);
            eb = ref_decode(ins, 0, 0);
            q_a.push_back(ea);
            q_b.push_back(eb);
            m_valid   = 1;
            m_load_rd = ea.memread ? ea.rd : 5'd0;
            if (ea.illegal && exp_cnt_a < 255) exp_cnt_a++;
            if (eb.illegal && exp_cnt_b < 255) exp_cnt_b++;
        end else if (ordy) begin
            m_valid = 0;
        end
    endtask

    task automatic mon(input bit k, input logic ov, input bundle_t got, input logic [7:0] cnt);
        bundle_t exp, z;
        int      n, ec;
        n  = k ? q_b.size() : q_a.size();
        ec = k ? exp_cnt_b : exp_cnt_a;
        checks++;
        if (cnt !== ec[7:0]) begin
            errors++;
            $display("FAIL illegal_count dut=%0d got=%0d exp=%0d", k, cnt, ec);
        end
        checks++;
        if (ov === 1'b1) begin
            if (n == 0) begin
                errors++;
                $display("FAIL unexpected_valid dut=%0d got=%h exp=none", k, got);
            end else begin
                exp = k ? q_b[0] : q_a[0];
                if (got !== exp) begin
                    errors++;
                    $display("FAIL bundle dut=%0d got=%h exp=%h", k, got, exp);
                end
                if (out_ready || flush || rst) begin
                    if (k) void'(q_b.pop_front()); else void'(q_a.pop_front());
                end
            end
        end else begin
            z = got;
            z.f3 = 0; z.rd = 0; z.rs1 = 0; z.rs2 = 0;
            if (n != 0 || ov !== 1'b0 || z !== '0) begin
                errors++;
                $display("FAIL idle_outputs dut=%0d ov=%b ctrl=%h pending=%0d exp=zero", k, ov, z, n);
                if (n != 0) begin
                    if (k) void'(q_b.pop_front()); else void'(q_a.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, ov_a, {br_a, mr_a, m2r_a, mw_a, as_a, rw_a, op_a, sz_a, sg_a, j_a, jr_a,
                          md_a, f3_a, rd_a, rs1_a, rs2_a, il_a}, cnt_a);
            mon(1, ov_b, {br_b, mr_b, m2r_b, mw_b, as_b, rw_b, op_b, sz_b, sg_b, j_b, jr_b,
                          md_b, f3_b, rd_b, rs1_b, rs2_b, il_b}, cnt_b);
        end
    end

    function automatic logic [31:0] gen_instr();
        logic [31:0] i;
        logic [6:0]  ops [10];
        logic [6:0]  f7s [4];
        ops = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h15};
        i = $urandom;
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFF;
        i[6:0]   = ops[$urandom_range(0, 9)];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        i[31:25] = f7s[$urandom_range(0, 3)];
        return i;
    endfunction

    initial begin
        bit          acc;
        logic [31:0] cur;
        step(0, 0, 0, 0, 1, acc);
        mon_en = 1;
        step(0, 0, 1, 0, 1, acc);
        step(0, 0, 1, 0, 0, acc);
        // addi, sub, mul (mul illegal on the M-disabled instance)
        step(1, 32'h00A00093, 1, 0, 0, acc);
        step(1, 32'h402081B3, 1, 0, 0, acc);
        step(1, 32'h022081B3, 1, 0, 0, acc);
        // lw x5 then dependent add: one bubble
        step(1, 32'h00012283, 1, 0, 0, acc);
        step(1, 32'h00528333, 1, 0, 0, acc);
        step(1, 32'h00528333, 1, 0, 0, acc);
        // lw x0 then add reading x0: no bubble
        step(1, 32'h00012003, 1, 0, 0, acc);
        step(1, 32'h00000333, 1, 0, 0, acc);
        // hold lw for 3 cycles, then release with an independent instruction
        step(1, 32'h00012283, 1, 0, 0, acc);
        for (int c = 0; c < 3; c++) step(1, 32'h00A00093, 0, 0, 0, acc);
        step(1, 32'h00A00093, 1, 0, 0, acc);
        // flush during a held load and pending hazard
        step(1, 32'h00012283, 1, 0, 0, acc);
        step(1, 32'h00528333, 0, 0, 0, acc);
        step(1, 32'h00528333, 1, 1, 0, acc);
        step(1, 32'h00528333, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);
        // saturating illegal stream
        for (int c = 0; c < 300; c++) step(1, 32'hFFFF_FFFF, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);
        checks++;
        if (cnt_a !== 8'hFF || cnt_b !== 8'hFF) begin
            errors++;
            $display("FAIL saturate got a=%0d b=%0d exp=255", cnt_a, cnt_b);
        end
        for (int c = 0; c < 5; c++) step(1, 32'hFFFF_FFFF, 1, 0, 0, acc);
        step(1, 32'hFFFF_FFFF, 0, 0, 1, acc);
        step(0, 0, 1, 0, 0, acc);
        // randomized traffic; an unaccepted instruction is usually re-offered
        cur = gen_instr();
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 9) < 8, cur, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0, acc);
            if (acc || $urandom_range(0, 3) == 0) cur = gen_instr();
        end
        for (int c = 0; c < 3; c++) step(0, 0, 1, 0, 0, acc);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain got a=%0d b=%0d exp=0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Registered, handshaked successor to the combinational main control decoder. It sits between fetch and execute and decodes one RV32I instruction per cycle into the existing control bundle plus jump, M-extension and illegal-instruction signals. It detects load-use hazards, inserting a one-cycle bubble, and supports pipeline flush. Outputs are fully defined, with no X, whenever out_valid=0 or an instruction is illegal.

Parameters:
ENABLE_M, 1, decode RV32M (funct7=0x01 on opcode 0110011); when 0, such encodings are illegal
ENABLE_JUMP, 1, decode JAL (1101111), JALR (1100111), LUI (0110111) and AUIPC (0010111); when 0, these are illegal
ILLEGAL_CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  instr is valid
in_ready  out  1  stage accepts instr this cycle
instr  in  32  raw instruction
flush  in  1  discard the held entry and any pending bubble
out_valid  out  1  registered bundle is valid
out_ready  in  1  downstream accepts the bundle
Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  same meaning as the existing decoder
ALUOp  out  alu_op_t  ALU operation from alu_op_pkg
MemReadSize  out  2  0=byte, 1=half, 2=word
MemReadSigned  out  1  sign-extend the load
Jump  out  1  JAL or JALR
JumpReg  out  1  JALR (target = rs1+imm)
MulDiv  out  1  M-extension op; funct3 selects the operation
funct3_o  out  3  registered funct3
rd, rs1, rs2  out  5 each  register indices
Illegal  out  1  undecodable instruction
illegal_count  out  ILLEGAL_CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (sync, rst=1 at a posedge): out_valid=0; all control outputs, rd/rs1/rs2, funct3_o and illegal_count = 0; hazard state cleared. in_ready=0 while rst=1.
- Handshake: accept when in_valid && in_ready. in_ready = !stall && (!out_valid || out_ready). Output updates on the edge after acceptance (latency 1). The bundle holds stable while out_valid && !out_ready.
- When out_valid=0 (bubble or empty), all control outputs are 0 (no side effects).
- Decode (control fields):
  - Loads, stores, branches, OP and OP-IMM match the existing decoder's mapping.
  - Illegal load funct3 (011, 110, 111) sets Illegal.
  - R-type with funct7 not in {0x00, 0x20, (0x01 if ENABLE_M)} is Illegal; 0x20 is valid only with funct3 000 or 101.
  - OP-IMM shifts: funct3=001 needs funct7=0x00; funct3=101 needs funct7 in {0x00, 0x20}.
  - Illegal instructions: out_valid=1, Illegal=1, and RegWrite, MemRead, MemWrite, Branch, Jump, MulDiv all 0.
- Decode (jump, upper-immediate, M):
  - JAL/JALR: Jump=1, RegWrite=1, ALUOp=ADD; JALR additionally JumpReg=1, ALUSrc=1, and needs funct3=000, else Illegal.
  - LUI/AUIPC: RegWrite=1, ALUSrc=1, ALUOp=ADD.
  - M ops: MulDiv=1, RegWrite=1, ALUSrc=0, ALUOp=ADD (ignored by the ALU).
- rs1/rs2 are always taken from instr[19:15]/[24:20]; rd from instr[11:7].
- Load-use hazard: a hazard exists when the held entry (out_valid=1) is a load with rd≠0, the incoming valid instruction reads that rd, and the bundle is being consumed this cycle.
  - rs1 counts as read by all types except LUI, AUIPC and JAL.
  - rs2 counts as read only by R-type, store and branch.
  - On a hazard the stage asserts stall for one cycle: in_ready=0 and a bubble is issued (out_valid=0). The next cycle the instruction is accepted normally. Exactly one bubble per hazard.
- flush: on the next edge out_valid=0 and any pending stall is cancelled. in_ready=0 during the flush cycle, so instr is not accepted. flush overrides out_ready and hazards.
- illegal_count increments on each accepted Illegal instruction and saturates at all-ones. It is not cleared by flush.
- rst asserted mid-stall or mid-hold behaves identically to reset from idle.

Test Plan:
- addi x1,x0,10 (0x00A00093), out_ready=1 -> next cycle out_valid=1, RegWrite=1, ALUSrc=1, ALUOp=ADD, rd=1, Illegal=0.
- sub x3,x1,x2 (0x402081B3), then mul x3,x1,x2 (0x022081B3) with ENABLE_M=1 -> ALUOp=SUB; then MulDiv=1, funct3_o=0. Same mul with ENABLE_M=0 -> Illegal=1, RegWrite=0, illegal_count=1.
- lw x5,0(x2) (0x00012283) followed back-to-back by add x6,x5,x5 (0x00528333) -> lw bundle (MemRead=1, MemReadSize=2); one cycle with out_valid=0 and in_ready=0; then add with rd=6. Same test with rd=x0 (lw x0) -> no bubble.
- Hold lw with out_ready=0 for 3 cycles -> bundle stable, in_ready=0; release -> next instruction accepted on the following edge.
- Assert flush during a held entry and pending hazard -> next cycle out_valid=0, no bubble, subsequent instruction accepted normally.
- Stream 300 instructions of 0xFFFFFFFF with ILLEGAL_CNT_W=8 -> illegal_count saturates at 255; rst mid-stream -> all outputs 0 on the next edge.
